// File: rtl/hps_master_bytes_to_packets.sv
// Byte-stream to Avalon-ST packet decoder for the HPS-only master (0x7A SOP, 0x7B EOP, 0x7C channel, 0x7D escape).
// Optional protocol-error flag enabled by defining HPS_B2P_PROTO_ERR_EN.
module hps_master_bytes_to_packets #(
  parameter logic [7:0] ESC_XOR = 8'h20
) (
  input  logic       clk,
  input  logic       reset_n,
  output logic       in_ready,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  input  logic       out_ready,
  output logic       out_valid,
  output logic [7:0] out_data,
  output logic [7:0] out_channel,
  output logic       out_startofpacket,
  output logic       out_endofpacket
`ifdef HPS_B2P_PROTO_ERR_EN
  ,
  output logic       proto_error
`endif
);

  localparam logic [1:0] NORM     = 2'd0;
  localparam logic [1:0] ESC      = 2'd1;
  localparam logic [1:0] CHAN     = 2'd2;
  localparam logic [1:0] CHAN_ESC = 2'd3;

  logic [1:0] state, state_nxt;
  logic [7:0] chan, chan_nxt;
  logic       sop_pend, sop_nxt, eop_pend, eop_nxt;
  logic       accept, load;
  logic [7:0] load_data;

  assign in_ready = out_ready | ~out_valid;
  assign accept   = in_valid & in_ready;

  always_comb begin
    state_nxt = state;
    chan_nxt  = chan;
    sop_nxt   = sop_pend;
    eop_nxt   = eop_pend;
    load      = 1'b0;
    load_data = in_data;
    if (accept) begin
      case (state)
        NORM: begin
          case (in_data)
            8'h7A: begin sop_nxt = 1'b1; eop_nxt = 1'b0; end
            8'h7B: eop_nxt = 1'b1;
            8'h7C: state_nxt = CHAN;
            8'h7D: state_nxt = ESC;
            default: load = 1'b1;
          endcase
        end
        ESC: begin
          load      = 1'b1;
          load_data = in_data ^ ESC_XOR;
          state_nxt = NORM;
        end
        CHAN: begin
          // Channel byte is literal unless escaped; marker values are legal channels here.
          if (in_data == 8'h7D) state_nxt = CHAN_ESC;
          else begin
            chan_nxt  = in_data;
            state_nxt = NORM;
          end
        end
        default: begin
          chan_nxt  = in_data ^ ESC_XOR;
          state_nxt = NORM;
        end
      endcase
    end
    if (load) begin
      sop_nxt = 1'b0;
      eop_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= NORM;
      chan     <= 8'h00;
      sop_pend <= 1'b0;
      eop_pend <= 1'b0;
    end else begin
      state    <= state_nxt;
      chan     <= chan_nxt;
      sop_pend <= sop_nxt;
      eop_pend <= eop_nxt;
    end
  end

  // Beat takes the flags and channel as they stood before this byte.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid         <= 1'b0;
      out_data          <= 8'h00;
      out_channel       <= 8'h00;
      out_startofpacket <= 1'b0;
      out_endofpacket   <= 1'b0;
    end else if (load) begin
      out_valid         <= 1'b1;
      out_data          <= load_data;
      out_channel       <= chan;
      out_startofpacket <= sop_pend;
      out_endofpacket   <= eop_pend;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef HPS_B2P_PROTO_ERR_EN
  logic in_pkt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      in_pkt      <= 1'b0;
      proto_error <= 1'b0;
    end else begin
      proto_error <= load & (sop_pend ? in_pkt : ~in_pkt);
      if (load) begin
        if (eop_pend)      in_pkt <= 1'b0;
        else if (sop_pend) in_pkt <= 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_hps_master_bytes_to_packets.sv
// Bench for hps_master_bytes_to_packets: directed vector table, stall/reset sequences, randomized stream vs. reference decoder.
module tb_hps_master_bytes_to_packets;
  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       in_ready, in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       out_ready = 1'b1;
  logic       out_valid, out_startofpacket, out_endofpacket;
  logic [7:0] out_data, out_channel;
`ifdef HPS_B2P_PROTO_ERR_EN
  logic       proto_error;
`endif

  hps_master_bytes_to_packets dut (
    .clk(clk), .reset_n(reset_n),
    .in_ready(in_ready), .in_valid(in_valid), .in_data(in_data),
    .out_ready(out_ready), .out_valid(out_valid), .out_data(out_data),
    .out_channel(out_channel), .out_startofpacket(out_startofpacket),
    .out_endofpacket(out_endofpacket)
`ifdef HPS_B2P_PROTO_ERR_EN
    , .proto_error(proto_error)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit rnd_mode = 1'b0;

  // beat record: {eop, sop, channel, data}
  logic [17:0] got[$];
  logic [17:0] exp_q[$];
  logic [7:0]  rq[$];
  logic        pe[$];

  typedef struct {
    int          nb;
    logic [7:0]  b[8];
    int          nq;
    logic [17:0] q[3];
  } vec_t;
  vec_t tv[5];

  function automatic logic [17:0] bt(logic [7:0] d, logic [7:0] ch, logic s, logic e);
    return {e, s, ch, d};
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, expv);
    end
  endtask

  // Transfer happens at the next posedge when valid & ready seen here.
  always @(negedge clk) begin
    if (reset_n && out_valid && out_ready) begin
      got.push_back({out_endofpacket, out_startofpacket, out_channel, out_data});
`ifdef HPS_B2P_PROTO_ERR_EN
      pe.push_back(proto_error);
`endif
    end
  end

  always @(posedge clk) begin
    #1;
    if (rnd_mode) out_ready = ($urandom_range(0, 3) != 0);
  end

  // Caller is positioned just after a posedge; returns just after the accepting posedge.
  task automatic send_byte(input logic [7:0] b, input bit gaps, input bit want_ready);
    int  t;
    bit  acc;
    t = 0;
    if (gaps) begin
      in_valid = 1'b0;
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end
    in_valid = 1'b1;
    in_data  = b;
    forever begin
      @(negedge clk);
      acc = in_ready;
      if (want_ready) chk("in_ready_held", 32'(in_ready), 32'd1);
      @(posedge clk); #1;
      if (acc) break;
      t++;
      if (t > 200) begin
        chk("accept_timeout", 32'(t), 32'd0);
        break;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic cmp_beats(string nm);
    chk({nm, "_count"}, 32'(got.size()), 32'(exp_q.size()));
    for (int k = 0; k < exp_q.size() && k < got.size(); k++)
      chk(nm, 32'(got[k]), 32'(exp_q[k]));
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    idle(2);
    reset_n = 1'b1;
    idle(1);
  endtask

  // Reference decoder: walks the whole byte list, consuming multi-byte sequences at once.
  function automatic void ref_decode();
    int         i;
    logic [7:0] b, c, ch;
    logic       sop, eop;
    i = 0; ch = 8'h00; sop = 1'b0; eop = 1'b0;
    exp_q.delete();
    while (i < rq.size()) begin
      b = rq[i]; i++;
      if (b == 8'h7A) begin sop = 1'b1; eop = 1'b0; end
      else if (b == 8'h7B) eop = 1'b1;
      else if (b == 8'h7C) begin
        if (i < rq.size()) begin
          c = rq[i]; i++;
          if (c != 8'h7D) ch = c;
          else if (i < rq.size()) begin ch = rq[i] ^ 8'h20; i++; end
        end
      end else begin
        if (b == 8'h7D) begin
          if (i >= rq.size()) break;
          b = rq[i] ^ 8'h20; i++;
        end
        exp_q.push_back(bt(b, ch, sop, eop));
        sop = 1'b0; eop = 1'b0;
      end
    end
  endfunction

  initial begin
    tv[0] = '{8, '{8'h7A, 8'h7D, 8'h5A, 8'h7D, 8'h5D, 8'h7B, 8'h7D, 8'h5B}, 3,
              '{bt(8'h7A, 8'h00, 1, 0), bt(8'h7D, 8'h00, 0, 0), bt(8'h7B, 8'h00, 0, 1)}};
    tv[1] = '{7, '{8'h7A, 8'h7C, 8'h05, 8'h11, 8'h22, 8'h7B, 8'h33, 8'h00}, 3,
              '{bt(8'h11, 8'h05, 1, 0), bt(8'h22, 8'h05, 0, 0), bt(8'h33, 8'h05, 0, 1)}};
    tv[2] = '{6, '{8'h7C, 8'h7D, 8'h5C, 8'h7A, 8'h7B, 8'h44, 8'h00, 8'h00}, 1,
              '{bt(8'h44, 8'h7C, 1, 1), 18'h0, 18'h0}};
    tv[3] = '{7, '{8'h7C, 8'h7A, 8'h7A, 8'h7A, 8'h7B, 8'h7A, 8'h55, 8'h00}, 1,
              '{bt(8'h55, 8'h7A, 1, 0), 18'h0, 18'h0}};
    tv[4] = '{7, '{8'h7B, 8'h7D, 8'h7A, 8'h7C, 8'h7D, 8'h20, 8'h77, 8'h00}, 2,
              '{bt(8'h5A, 8'h7A, 0, 1), bt(8'h77, 8'h00, 0, 0), 18'h0}};

    // reset state
    idle(2);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_out_channel", 32'(out_channel), 32'd0);
    chk("rst_sop_eop", 32'({out_startofpacket, out_endofpacket}), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    reset_n = 1'b1;
    idle(1);

    // directed vector table, out_ready held high
    for (int i = 0; i < 5; i++) begin
      got.delete(); exp_q.delete();
      for (int j = 0; j < tv[i].nb; j++) send_byte(tv[i].b[j], 1'b0, 1'b1);
      idle(3);
      for (int k = 0; k < tv[i].nq; k++) exp_q.push_back(tv[i].q[k]);
      cmp_beats($sformatf("vec%0d", i));
    end

    // backpressure: first beat held while out_ready low, then back-to-back drain
    got.delete(); exp_q.delete();
    out_ready = 1'b0;
    send_byte(8'h7A, 1'b0, 1'b0);
    send_byte(8'h01, 1'b0, 1'b0);
    in_valid = 1'b1; in_data = 8'h02;
    repeat (3) begin
      @(negedge clk);
      chk("stall_valid", 32'(out_valid), 32'd1);
      chk("stall_data", 32'(out_data), 32'h01);
      chk("stall_in_ready", 32'(in_ready), 32'd0);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    send_byte(8'h02, 1'b0, 1'b1);
    @(negedge clk);
    chk("release_beat02", 32'({out_valid, out_data}), 32'h102);
    @(posedge clk); #1;
    send_byte(8'h03, 1'b0, 1'b1);
    @(negedge clk);
    chk("release_beat03", 32'({out_valid, out_data}), 32'h103);
    @(posedge clk); #1;
    idle(2);
    exp_q.push_back(bt(8'h01, 8'h00, 1, 0));
    exp_q.push_back(bt(8'h02, 8'h00, 0, 0));
    exp_q.push_back(bt(8'h03, 8'h00, 0, 0));
    cmp_beats("stall");

    // reset in the middle of a channel sequence discards it
    got.delete(); exp_q.delete();
    send_byte(8'h7C, 1'b0, 1'b1);
    reset_n = 1'b0;
    #1;
    chk("midrst_valid", 32'(out_valid), 32'd0);
    idle(2);
    reset_n = 1'b1;
    idle(1);
    send_byte(8'h7A, 1'b0, 1'b1);
    send_byte(8'h09, 1'b0, 1'b1);
    idle(3);
    exp_q.push_back(bt(8'h09, 8'h00, 1, 0));
    cmp_beats("midrst");

`ifdef HPS_B2P_PROTO_ERR_EN
    do_reset();
    got.delete(); pe.delete();
    rq = '{8'h7A, 8'h01, 8'h7A, 8'h02, 8'h7B, 8'h03, 8'h04};
    foreach (rq[i]) send_byte(rq[i], 1'b0, 1'b1);
    idle(3);
    chk("perr_count", 32'(pe.size()), 32'd4);
    if (pe.size() == 4)
      chk("perr_pulses", 32'({pe[0], pe[1], pe[2], pe[3]}), 32'b0101);
`endif

    // randomized stream with gaps and random backpressure
    do_reset();
    got.delete(); rq.delete();
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 9) < 4) rq.push_back(8'h7A + 8'($urandom_range(0, 3)));
      else rq.push_back(8'($urandom_range(0, 255)));
    end
    rnd_mode = 1'b1;
    foreach (rq[i]) send_byte(rq[i], 1'b1, 1'b0);
    idle(30);
    rnd_mode = 1'b0;
    out_ready = 1'b1;
    idle(3);
    ref_decode();
    cmp_beats("random");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got timeout expected completion");
    $fatal(1);
  end
endmodule
